// File: rtl/lcd_bus_responder.sv
// HD44780-style bus responder with a 2x16 DDRAM.
// Completes transactions on E falling edges and models the busy flag.
module lcd_bus_responder #(
    parameter int BUSY_CYCLES      = 4,
    parameter int LONG_BUSY_CYCLES = 40
) (
    input  logic       mclk,
    input  logic       rst,
    input  logic       lcd_e,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic [7:0] lcd_data_in,
    output logic [7:0] lcd_data_out,
    output logic       lcd_data_oe,
    output logic       busy,
    output logic [6:0] addr_ctr,
    output logic       disp_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       inc_mode,
    output logic       protocol_err,
    input  logic [4:0] dbg_addr,
    output logic [7:0] dbg_char
);

    localparam int LONG_EFF = (LONG_BUSY_CYCLES < 32) ? 32 : LONG_BUSY_CYCLES;
    localparam logic [15:0] CNT_BUSY = 16'(BUSY_CYCLES - 1);
    localparam logic [15:0] CNT_LONG = 16'(LONG_EFF - 1);
    localparam logic [15:0] CNT_TAIL = 16'(LONG_EFF - 33);
    localparam bit HAS_TAIL = (LONG_EFF > 32);

    typedef enum logic [1:0] {INIT, IDLE, EXEC, CLEAR} state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [4:0]  fill_q, fill_d;
    logic        e_q, rs_q, rs_d, rw_q, rw_d;
    logic [7:0]  data_q, data_d;
    logic [6:0]  addr_q, addr_d;
    logic        disp_q, disp_d, cur_q, cur_d, blink_q, blink_d;
    logic        inc_q, inc_d, err_q, err_d;

    logic [7:0]  ddram [32];
    logic        we;
    logic [4:0]  widx;
    logic [7:0]  wdata;
    logic [4:0]  cur_idx;
    logic        fall;

    function automatic logic [6:0] step(input logic [6:0] a, input logic up);
        if (up) begin
            if (a == 7'h0F) return 7'h40;
            if (a == 7'h4F) return 7'h00;
            return a + 7'd1;
        end
        if (a == 7'h00) return 7'h4F;
        if (a == 7'h40) return 7'h0F;
        return a - 7'd1;
    endfunction

    assign busy    = (state_q != IDLE);
    assign fall    = e_q & ~lcd_e;
    assign cur_idx = {addr_q[6], addr_q[3:0]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fill_d  = fill_q;
        rs_d    = rs_q;
        rw_d    = rw_q;
        data_d  = data_q;
        addr_d  = addr_q;
        disp_d  = disp_q;
        cur_d   = cur_q;
        blink_d = blink_q;
        inc_d   = inc_q;
        err_d   = err_q;
        we      = 1'b0;
        widx    = fill_q;
        wdata   = 8'h20;
        if (lcd_e) begin
            rs_d   = lcd_rs;
            rw_d   = lcd_rw;
            data_d = lcd_data_in;
        end
        unique case (state_q)
            INIT: begin
                we     = 1'b1;
                fill_d = fill_q + 5'd1;
                if (fill_q == 5'd31) state_d = IDLE;
            end
            CLEAR: begin
                we     = 1'b1;
                fill_d = fill_q + 5'd1;
                if (fill_q == 5'd31) begin
                    if (HAS_TAIL) begin
                        state_d = EXEC;
                        cnt_d   = CNT_TAIL;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            EXEC: begin
                if (cnt_q == 16'd0) state_d = IDLE;
                else cnt_d = cnt_q - 16'd1;
            end
            default: ;
        endcase
        // Status reads are always legal; anything else while busy is dropped.
        if (fall) begin
            if (busy) begin
                if (!rw_q || rs_q) err_d = 1'b1;
            end else if (rw_q) begin
                if (rs_q) addr_d = step(addr_q, inc_q);
            end else if (rs_q) begin
                we      = 1'b1;
                widx    = cur_idx;
                wdata   = data_q;
                addr_d  = step(addr_q, inc_q);
                state_d = EXEC;
                cnt_d   = CNT_BUSY;
            end else if (data_q[7]) begin
                if (data_q[6:4] == 3'b000 || data_q[6:4] == 3'b100) begin
                    addr_d = data_q[6:0];
                end else begin
                    addr_d = 7'h00;
                    err_d  = 1'b1;
                end
                state_d = EXEC;
                cnt_d   = CNT_BUSY;
            end else if (|data_q[6:4]) begin
                state_d = EXEC;
                cnt_d   = CNT_BUSY;
            end else if (data_q[3]) begin
                disp_d  = data_q[2];
                cur_d   = data_q[1];
                blink_d = data_q[0];
                state_d = EXEC;
                cnt_d   = CNT_BUSY;
            end else if (data_q[2]) begin
                inc_d   = data_q[1];
                state_d = EXEC;
                cnt_d   = CNT_BUSY;
            end else if (data_q[1]) begin
                addr_d  = 7'h00;
                state_d = EXEC;
                cnt_d   = CNT_LONG;
            end else if (data_q[0]) begin
                addr_d  = 7'h00;
                inc_d   = 1'b1;
                fill_d  = 5'd0;
                state_d = CLEAR;
            end
        end
    end

    always_ff @(posedge mclk or negedge rst) begin
        if (!rst) begin
            state_q <= INIT;
            cnt_q   <= '0;
            fill_q  <= '0;
            e_q     <= 1'b0;
            rs_q    <= 1'b0;
            rw_q    <= 1'b0;
            data_q  <= '0;
            addr_q  <= '0;
            disp_q  <= 1'b0;
            cur_q   <= 1'b0;
            blink_q <= 1'b0;
            inc_q   <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fill_q  <= fill_d;
            e_q     <= lcd_e;
            rs_q    <= rs_d;
            rw_q    <= rw_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            disp_q  <= disp_d;
            cur_q   <= cur_d;
            blink_q <= blink_d;
            inc_q   <= inc_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge mclk) begin
        if (we) ddram[widx] <= wdata;
    end

    always_comb begin
        lcd_data_oe  = rst & lcd_e & lcd_rw;
        lcd_data_out = 8'h00;
        if (lcd_data_oe) begin
            if (lcd_rs) lcd_data_out = busy ? 8'h00 : ddram[cur_idx];
            else lcd_data_out = {busy, addr_q};
        end
    end

    assign addr_ctr     = addr_q;
    assign disp_on      = disp_q;
    assign cursor_on    = cur_q;
    assign blink_on     = blink_q;
    assign inc_mode     = inc_q;
    assign protocol_err = err_q;
    assign dbg_char     = ddram[dbg_addr];

endmodule

// File: tb/tb_lcd_bus_responder.sv
// Bench for lcd_bus_responder: directed vector table, corner sequences,
// and random bus traffic against a linear-index screen model.
module tb_lcd_bus_responder;

    localparam int BUSY = 4;
    localparam int LONG = 40;

    logic       mclk = 1'b0;
    logic       rst = 1'b0;
    logic       lcd_e = 1'b0, lcd_rs = 1'b0, lcd_rw = 1'b0;
    logic [7:0] lcd_data_in = 8'h00;
    logic [7:0] lcd_data_out;
    logic       lcd_data_oe, busy;
    logic [6:0] addr_ctr;
    logic       disp_on, cursor_on, blink_on, inc_mode, protocol_err;
    logic [4:0] dbg_addr = 5'd0;
    logic [7:0] dbg_char;

    lcd_bus_responder #(.BUSY_CYCLES(BUSY), .LONG_BUSY_CYCLES(LONG)) dut (
        .mclk(mclk), .rst(rst),
        .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
        .lcd_data_in(lcd_data_in),
        .lcd_data_out(lcd_data_out), .lcd_data_oe(lcd_data_oe),
        .busy(busy), .addr_ctr(addr_ctr),
        .disp_on(disp_on), .cursor_on(cursor_on),
        .blink_on(blink_on), .inc_mode(inc_mode),
        .protocol_err(protocol_err),
        .dbg_addr(dbg_addr), .dbg_char(dbg_char)
    );

    always #5 mclk = ~mclk;

    int cyc = 0;
    always @(posedge mclk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail = 0;

    // Model: screen as 32 linear cells, cursor as a linear index.
    logic [7:0] m_mem [32];
    int m_lin;
    bit m_inc, m_disp, m_cur, m_blink, m_err;
    int m_busy_until;
    logic [7:0] last_rd;

    function automatic bit m_busy();
        return cyc < m_busy_until;
    endfunction

    function automatic logic [6:0] lin2addr(int l);
        return 7'((l / 16) * 64 + (l % 16));
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_state(string tag);
        chk({tag, ".busy"}, 32'(busy), 32'(m_busy()));
        chk({tag, ".addr"}, 32'(addr_ctr), 32'(lin2addr(m_lin)));
        chk({tag, ".disp"}, 32'(disp_on), 32'(m_disp));
        chk({tag, ".cursor"}, 32'(cursor_on), 32'(m_cur));
        chk({tag, ".blink"}, 32'(blink_on), 32'(m_blink));
        chk({tag, ".inc"}, 32'(inc_mode), 32'(m_inc));
        chk({tag, ".err"}, 32'(protocol_err), 32'(m_err));
    endtask

    task automatic idle(int n);
        repeat (n) begin
            @(negedge mclk);
            check_state("idle");
        end
    endtask

    task automatic check_mem();
        for (int i = 0; i < 32; i++) begin
            dbg_addr = 5'(i);
            #1;
            chk($sformatf("ddram[%0d]", i), 32'(dbg_char), 32'(m_mem[i]));
        end
    endtask

    task automatic bus_op(bit rs, bit rw, logic [7:0] d);
        int cb;
        int ms;
        bit acc;
        logic [7:0] exp;
        logic [6:0] a;
        lcd_rs = rs;
        lcd_rw = rw;
        lcd_data_in = d;
        lcd_e = 1'b1;
        @(negedge mclk);
        if (rw) begin
            if (rs) exp = m_busy() ? 8'h00 : m_mem[m_lin];
            else exp = {m_busy(), lin2addr(m_lin)};
            chk("rd_oe", 32'(lcd_data_oe), 32'd1);
            chk("rd_data", 32'(lcd_data_out), 32'(exp));
            last_rd = lcd_data_out;
        end
        acc = !m_busy();
        lcd_e = 1'b0;
        lcd_data_in = 8'($urandom);
        #1;
        chk("oe_low", 32'(lcd_data_oe), 32'd0);
        chk("out_low", 32'(lcd_data_out), 32'd0);
        @(negedge mclk);
        cb = cyc;
        if (!acc) begin
            if (!rw || rs) m_err = 1'b1;
        end else if (rw) begin
            if (rs) m_lin = m_inc ? (m_lin + 1) % 32 : (m_lin + 31) % 32;
        end else if (rs) begin
            m_mem[m_lin] = d;
            m_lin = m_inc ? (m_lin + 1) % 32 : (m_lin + 31) % 32;
            m_busy_until = cb + BUSY;
        end else begin
            ms = -1;
            for (int b = 7; b >= 0; b--)
                if (d[b] && ms < 0) ms = b;
            case (ms)
                7: begin
                    a = d[6:0];
                    if (a < 7'h10) m_lin = int'(a);
                    else if (a >= 7'h40 && a < 7'h50) m_lin = 16 + int'(a) - 64;
                    else begin
                        m_lin = 0;
                        m_err = 1'b1;
                    end
                    m_busy_until = cb + BUSY;
                end
                6, 5, 4: m_busy_until = cb + BUSY;
                3: begin
                    m_disp = d[2];
                    m_cur = d[1];
                    m_blink = d[0];
                    m_busy_until = cb + BUSY;
                end
                2: begin
                    m_inc = d[1];
                    m_busy_until = cb + BUSY;
                end
                1: begin
                    m_lin = 0;
                    m_busy_until = cb + LONG;
                end
                0: begin
                    for (int i = 0; i < 32; i++) m_mem[i] = 8'h20;
                    m_lin = 0;
                    m_inc = 1'b1;
                    m_busy_until = cb + LONG;
                end
                default: ;
            endcase
        end
        check_state("op");
    endtask

    task automatic do_reset();
        rst = 1'b0;
        lcd_e = 1'b1;
        lcd_rw = 1'b1;
        lcd_rs = 1'b0;
        @(negedge mclk);
        @(negedge mclk);
        chk("rst.busy", 32'(busy), 32'd1);
        chk("rst.addr", 32'(addr_ctr), 32'd0);
        chk("rst.disp", 32'(disp_on), 32'd0);
        chk("rst.cursor", 32'(cursor_on), 32'd0);
        chk("rst.blink", 32'(blink_on), 32'd0);
        chk("rst.inc", 32'(inc_mode), 32'd1);
        chk("rst.err", 32'(protocol_err), 32'd0);
        chk("rst.oe", 32'(lcd_data_oe), 32'd0);
        chk("rst.out", 32'(lcd_data_out), 32'd0);
        lcd_e = 1'b0;
        lcd_rw = 1'b0;
        @(negedge mclk);
        rst = 1'b1;
        for (int i = 0; i < 32; i++) m_mem[i] = 8'h20;
        m_lin = 0;
        m_inc = 1'b1;
        m_disp = 1'b0;
        m_cur = 1'b0;
        m_blink = 1'b0;
        m_err = 1'b0;
        m_busy_until = cyc + 32;
        idle(31);
        chk("init.busy_31", 32'(busy), 32'd1);
        idle(1);
        chk("init.busy_32", 32'(busy), 32'd0);
        check_mem();
        @(negedge mclk);
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 200) begin
            n++;
            @(negedge mclk);
        end
    endtask

    typedef struct {
        bit         rs;
        bit         rw;
        logic [7:0] d;
        logic [6:0] exp_addr;
        logic [7:0] exp_rd;
    } vec_t;

    vec_t vt [17];
    int nb;
    logic [7:0] d;

    initial begin
        vt[0]  = '{0, 0, 8'h0F, 7'h00, 8'h00};
        vt[1]  = '{0, 0, 8'h06, 7'h00, 8'h00};
        vt[2]  = '{1, 0, 8'h41, 7'h01, 8'h00};
        vt[3]  = '{0, 0, 8'h8F, 7'h0F, 8'h00};
        vt[4]  = '{1, 0, 8'h78, 7'h40, 8'h00};
        vt[5]  = '{1, 0, 8'h79, 7'h41, 8'h00};
        vt[6]  = '{0, 0, 8'h04, 7'h41, 8'h00};
        vt[7]  = '{1, 1, 8'h00, 7'h40, 8'h20};
        vt[8]  = '{0, 0, 8'h80, 7'h00, 8'h00};
        vt[9]  = '{1, 1, 8'h00, 7'h4F, 8'h41};
        vt[10] = '{0, 0, 8'hC0, 7'h40, 8'h00};
        vt[11] = '{1, 1, 8'h00, 7'h0F, 8'h79};
        vt[12] = '{0, 0, 8'h06, 7'h0F, 8'h00};
        vt[13] = '{0, 0, 8'hCF, 7'h4F, 8'h00};
        vt[14] = '{1, 1, 8'h00, 7'h00, 8'h20};
        vt[15] = '{0, 1, 8'h00, 7'h00, 8'h00};
        vt[16] = '{0, 0, 8'h00, 7'h00, 8'h00};

        do_reset();
        chk("init.addr", 32'(addr_ctr), 32'd0);

        for (int i = 0; i < 17; i++) begin
            bus_op(vt[i].rs, vt[i].rw, vt[i].d);
            chk($sformatf("vec%0d.addr", i), 32'(addr_ctr), 32'(vt[i].exp_addr));
            if (vt[i].rw)
                chk($sformatf("vec%0d.rd", i), 32'(last_rd), 32'(vt[i].exp_rd));
            idle(6);
        end
        chk("vec.disp", 32'(disp_on), 32'd1);
        chk("vec.cursor", 32'(cursor_on), 32'd1);
        chk("vec.blink", 32'(blink_on), 32'd1);
        chk("vec.inc", 32'(inc_mode), 32'd1);
        chk("vec.err", 32'(protocol_err), 32'd0);
        dbg_addr = 5'd0;
        #1 chk("vec.ch0", 32'(dbg_char), 32'h41);
        dbg_addr = 5'd15;
        #1 chk("vec.ch15", 32'(dbg_char), 32'h78);
        dbg_addr = 5'd16;
        #1 chk("vec.ch16", 32'(dbg_char), 32'h79);
        @(negedge mclk);

        bus_op(0, 0, 8'hA0);
        chk("badaddr.addr", 32'(addr_ctr), 32'd0);
        chk("badaddr.err", 32'(protocol_err), 32'd1);
        idle(6);

        bus_op(1, 0, 8'h42);
        count_busy(nb);
        chk("write.busy_len", 32'(nb), 32'(BUSY));
        bus_op(0, 0, 8'h01);
        count_busy(nb);
        chk("clear.busy_len", 32'(nb), 32'(LONG));
        idle(2);

        bus_op(1, 0, 8'h45);
        idle(6);
        bus_op(0, 0, 8'h01);
        bus_op(1, 0, 8'h5A);
        chk("clrbusy.addr", 32'(addr_ctr), 32'd0);
        bus_op(0, 1, 8'h00);
        chk("clrbusy.rd7", 32'(last_rd[7]), 32'd1);
        chk("clrbusy.err", 32'(protocol_err), 32'd1);
        idle(LONG);
        check_mem();
        dbg_addr = 5'd1;
        #1 chk("clrbusy.ch1", 32'(dbg_char), 32'h20);
        @(negedge mclk);

        bus_op(0, 0, 8'h01);
        idle(10);
        do_reset();
        chk("rstclr.err", 32'(protocol_err), 32'd0);

        bus_op(1, 0, 8'h50);
        idle(BUSY - 1);
        bus_op(1, 0, 8'h51);
        chk("edge.ok_addr", 32'(addr_ctr), 32'd2);
        chk("edge.ok_err", 32'(protocol_err), 32'd0);
        idle(BUSY - 2);
        bus_op(1, 0, 8'h52);
        chk("edge.drop_addr", 32'(addr_ctr), 32'd2);
        chk("edge.drop_err", 32'(protocol_err), 32'd1);
        idle(BUSY + 2);

        for (int k = 0; k < 250; k++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: bus_op(1, 0, 8'($urandom_range(32, 126)));
                4, 5: bus_op(1, 1, 8'h00);
                6: bus_op(0, 1, 8'h00);
                default: begin
                    case ($urandom_range(0, 11))
                        0: d = 8'h80 | 8'($urandom_range(0, 127));
                        1, 2: d = 8'h80 | ($urandom_range(0, 1) ? 8'h40 : 8'h00)
                                  | 8'($urandom_range(0, 15));
                        3, 4: d = 8'h08 | 8'($urandom_range(0, 7));
                        5, 6: d = 8'h04 | 8'($urandom_range(0, 3));
                        7: d = 8'($urandom_range(16, 127));
                        8: d = 8'h00;
                        9: d = 8'h02 | 8'($urandom_range(0, 1));
                        10: d = 8'h01;
                        default: d = 8'h06;
                    endcase
                    bus_op(0, 0, d);
                end
            endcase
            idle($urandom_range(0, 5));
            if (k % 25 == 24) begin
                idle(LONG + 2);
                check_mem();
                @(negedge mclk);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lcd_bus_responder.md
LCD_BUS_RESPONDER -- requirements
Module: lcd_bus_responder

Interface
REQ-001 SHALL have parameter BUSY_CYCLES, default 4, busy duration in mclk cycles for normal commands and data writes.
REQ-002 SHALL have parameter LONG_BUSY_CYCLES, default 40, busy duration for clear and home; values below 32 SHALL be treated as 32.
REQ-003 SHALL have port mclk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports lcd_e, lcd_rs, lcd_rw  input  1 each  HD44780 enable, register select, and read/write strobes.
REQ-006 SHALL have port lcd_data_in  input  8  bus data from the controller.
REQ-007 SHALL have ports lcd_data_out  output  8 and lcd_data_oe  output  1  read data and drive enable.
REQ-008 SHALL have port busy  output  1  busy flag.
REQ-009 SHALL have port addr_ctr  output  7  DDRAM address counter.
REQ-010 SHALL have ports disp_on, cursor_on, blink_on, inc_mode  output  1 each  display-control and entry-mode state.
REQ-011 SHALL have port protocol_err  output  1  sticky error flag.
REQ-012 SHALL have ports dbg_addr  input  5 and dbg_char  output  8  combinational DDRAM read; index 0-15 is line 1, index 16-31 is line 2.

Function
REQ-013 SHALL register lcd_e each cycle; a transaction completes on a falling edge (e_q=1, lcd_e=0); rs/rw/data SHALL be taken from the registered copies of the last cycle E was high.
REQ-014 While lcd_e=1 and lcd_rw=1, SHALL set lcd_data_oe=1; otherwise lcd_data_oe=0 and lcd_data_out=0x00.
REQ-015 Read with rs=0: lcd_data_out={busy, addr_ctr}; this read is legal while busy.
REQ-016 Read with rs=1: lcd_data_out=DDRAM[addr_ctr]; on the E falling edge, addr_ctr SHALL advance per REQ-022; if busy, the read returns 0x00, the address does not advance, and protocol_err is set.
REQ-017 Write completed while busy=1: SHALL be discarded and SHALL set protocol_err.
REQ-018 Data write (rs=0... rs=1, rw=0): DDRAM[addr_ctr]<=data, advance addr_ctr, busy for BUSY_CYCLES.
REQ-019 Command write (rs=0, rw=0): SHALL decode on the highest set bit:
  0x80 set address to data[6:0]; 0x40 CGRAM and 0x10 shift are accepted and otherwise ignored; 0x20 function set is accepted and otherwise ignored;
  0x08 disp/cursor/blink<=data[2:0]; 0x04 inc_mode<=data[1]; 0x02 home: addr 0, long busy; 0x01 clear: fill DDRAM with 0x20, addr 0, inc_mode=1, long busy; 0x00 no-op with no busy.
REQ-020 Valid addresses SHALL be 0x00-0x0F and 0x40-0x4F; a set-address to any other value SHALL load 0x00 and set protocol_err.
REQ-021 The FSM SHALL have states INIT (power-on fill), IDLE, EXEC (busy countdown), and CLEAR (fill one location per cycle, 32 cycles, then countdown of the remaining LONG_BUSY_CYCLES-32); busy=1 in every state except IDLE.
REQ-022 Increment SHALL wrap 0x0F->0x40 and 0x4F->0x00; decrement SHALL wrap 0x00->0x4F and 0x40->0x0F.
REQ-023 Busy countdown: busy SHALL rise the cycle after the falling edge and stay high exactly N cycles.
REQ-024 A falling edge in the same cycle busy drops SHALL be treated as busy, i.e. discarded.
REQ-025 protocol_err SHALL clear only on reset.

Reset
REQ-026 While rst=0: busy=1, addr_ctr=0, disp_on=0, cursor_on=0, blink_on=0, inc_mode=1, protocol_err=0, lcd_data_oe=0, lcd_data_out=0, FSM=INIT.
REQ-027 After rst deasserts, INIT SHALL write 0x20 to all 32 locations in 32 cycles, then enter IDLE with busy=0.
REQ-028 Reset asserted mid-CLEAR or mid-EXEC SHALL abort the operation and restart INIT after release.

Verification
REQ-029 Release reset, wait 32 cycles -> busy=0, every dbg_char=0x20, addr_ctr=0x00.
REQ-030 Commands 0x0F, then 0x06, then write 'A' -> disp/cursor/blink=1, inc_mode=1, DDRAM[0]=0x41, addr_ctr=0x01, busy high for 4 cycles.
REQ-031 Set address 0x8F, then write 'x','y' -> dbg_char[15]=0x78, dbg_char[16]=0x79, addr_ctr=0x41.
REQ-032 Issue 0x01, write during busy, then read busy flag -> write discarded, protocol_err=1, read returns bit7=1, DDRAM all 0x20 after 40 cycles.
REQ-033 Set address 0x20 -> addr_ctr=0x00, protocol_err=1.
REQ-034 Assert rst during CLEAR, then release -> INIT runs, busy=0 after 32 cycles, protocol_err=0.
